// File: rtl/conv_window_mac.sv
`timescale 1ns/1ps
// conv_window_mac: 3x3 window MAC producing numer/denom for the normalising divider, plus a 9-tap kernel loaded serially and committed at frame start.
// Latency: numer/denom/mac_valid 3 clocks after the window edge; out_valid/out_sof a further DIV_LATENCY clocks (8 total by default).
// Backpressure: none; one window per clock, the pipeline never stalls. Define CONV_LOAD_ERR_EN to add the sticky kload_err_o output.
module conv_window_mac #(
    parameter int DIV_LATENCY = 5
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        in_valid_i,
    input  logic        in_sof_i,
    input  logic [89:0] in_win_i,
    input  logic        kload_start_i,
    input  logic        kload_valid_i,
    input  logic [7:0]  kload_data_i,
    output logic [22:0] numer_o,
    output logic [14:0] denom_o,
    output logic        mac_valid_o,
    output logic        out_valid_o,
    output logic        out_sof_o,
`ifdef CONV_LOAD_ERR_EN
    output logic        kload_err_o,
`endif
    output logic        kernel_busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // Per-window side information that travels alongside the data path.
    typedef struct packed {
        logic        vld;
        logic        sof;
        logic [14:0] den;
    } meta_t;

    localparam meta_t META_RST = '{vld: 1'b0, sof: 1'b0, den: 15'd1};

    // Identity kernel: centre tap 1, all others 0 (element 4 is the centre).
    localparam logic [8:0][7:0] W_IDENT = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1,
                                           8'd0, 8'd0, 8'd0, 8'd0};

    // ---------------------------------------------------------------
    // Kernel load FSM, shadow bank and active bank
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [8:0][7:0]  s_q, s_d;
    logic [8:0][7:0]  w_q;
    logic [14:0]      den_q;
    logic             commit;
    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [11:0]      shd_sum;
    logic [14:0]      den_commit;
    logic [8:0][7:0]  w_eff;
    logic [14:0]      den_eff;

    // Load FSM: next state, shadow write selection and commit decision.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        s_d     = s_q;
        commit  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (kload_valid_i) begin
                    wr_en = 1'b1;
                    if (idx_q == 4'd8) begin
                        state_d = ST_PENDING;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_PENDING: begin
                // Commit reads the completed shadow bank before any restart overwrites it.
                if (in_valid_i && in_sof_i) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
        // A restart wins from any state; a word presented with it lands in tap 0.
        if (kload_start_i) begin
            state_d = ST_LOAD;
            wr_idx  = 4'd0;
            wr_en   = kload_valid_i;
            idx_d   = kload_valid_i ? 4'd1 : 4'd0;
        end
        if (wr_en) begin
            s_d[wr_idx] = kload_data_i;
        end
    end

    // Load FSM state, tap index and shadow bank registers.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
        end
    end

    // Weight sum of the shadow bank; an all-zero kernel commits denom 1 so the divider never sees 0.
    always_comb begin
        shd_sum = 12'd0;
        for (int i = 0; i < 9; i++) begin
            shd_sum = shd_sum + 12'(s_q[i]);
        end
        den_commit = (shd_sum == 12'd0) ? 15'd1 : 15'(shd_sum);
    end

    // Active kernel and denom, replaced atomically on commit.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            w_q   <= W_IDENT;
            den_q <= 15'd1;
        end else if (commit) begin
            w_q   <= s_q;
            den_q <= den_commit;
        end
    end

    // The sof window that commits already uses the new kernel.
    assign w_eff   = commit ? s_q : w_q;
    assign den_eff = commit ? den_commit : den_q;

    assign kernel_busy_o = (state_q != ST_IDLE);

    // ---------------------------------------------------------------
    // MAC pipeline: S1 products, S2 row sums, S3 total
    // ---------------------------------------------------------------
    logic [8:0][9:0]  pix;
    logic [17:0]      s1_prod_d [9];
    logic [17:0]      s1_prod_q [9];
    meta_t            s1_meta_q;
    logic [19:0]      s2_row_d  [3];
    logic [19:0]      s2_row_q  [3];
    meta_t            s2_meta_q;
    logic [22:0]      numer_d;
    logic [22:0]      numer_q;
    meta_t            s3_meta_q;

    assign pix = in_win_i;

    // S1 next state: one 10x8 product per tap.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            s1_prod_d[i] = 18'(pix[i]) * 18'(w_eff[i]);
        end
    end

    // S1 registers; data and denom only move on a valid window so idle cycles hold.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < 9; i++) begin
                s1_prod_q[i] <= 18'd0;
            end
            s1_meta_q <= META_RST;
        end else begin
            s1_meta_q.vld <= in_valid_i;
            s1_meta_q.sof <= in_valid_i & in_sof_i;
            if (in_valid_i) begin
                for (int i = 0; i < 9; i++) begin
                    s1_prod_q[i] <= s1_prod_d[i];
                end
                s1_meta_q.den <= den_eff;
            end
        end
    end

    // S2 next state: sum each kernel row.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            s2_row_d[r] = 20'(s1_prod_q[3*r]) + 20'(s1_prod_q[3*r+1])
                        + 20'(s1_prod_q[3*r+2]);
        end
    end

    // S2 registers.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int r = 0; r < 3; r++) begin
                s2_row_q[r] <= 20'd0;
            end
            s2_meta_q <= META_RST;
        end else begin
            s2_meta_q.vld <= s1_meta_q.vld;
            s2_meta_q.sof <= s1_meta_q.sof;
            if (s1_meta_q.vld) begin
                for (int r = 0; r < 3; r++) begin
                    s2_row_q[r] <= s2_row_d[r];
                end
                s2_meta_q.den <= s1_meta_q.den;
            end
        end
    end

    // S3 next state: total of the three rows; max 2347785 fits in 23 bits.
    assign numer_d = 23'(s2_row_q[0]) + 23'(s2_row_q[1]) + 23'(s2_row_q[2]);

    // S3 registers drive the divider; they hold their last window between valids.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            numer_q   <= 23'd0;
            s3_meta_q <= META_RST;
        end else begin
            s3_meta_q.vld <= s2_meta_q.vld;
            s3_meta_q.sof <= s2_meta_q.sof;
            if (s2_meta_q.vld) begin
                numer_q       <= numer_d;
                s3_meta_q.den <= s2_meta_q.den;
            end
        end
    end

    assign numer_o     = numer_q;
    assign denom_o     = s3_meta_q.den;
    assign mac_valid_o = s3_meta_q.vld;

    // ---------------------------------------------------------------
    // valid/sof delay matching the divider's pipeline depth
    // ---------------------------------------------------------------
    logic [DIV_LATENCY-1:0] vdly_q;
    logic [DIV_LATENCY-1:0] sdly_q;

    // Shift mac valid/sof so they line up with the divider quotient.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            vdly_q <= '0;
            sdly_q <= '0;
        end else begin
            vdly_q[0] <= s3_meta_q.vld;
            sdly_q[0] <= s3_meta_q.vld & s3_meta_q.sof;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                vdly_q[i] <= vdly_q[i-1];
                sdly_q[i] <= sdly_q[i-1];
            end
        end
    end

    assign out_valid_o = vdly_q[DIV_LATENCY-1];
    assign out_sof_o   = sdly_q[DIV_LATENCY-1];

`ifdef CONV_LOAD_ERR_EN
    logic err_q;

    // Sticky load error: sof during a load, or a stray word while awaiting commit.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_LOAD && in_valid_i && in_sof_i) ||
                     (state_q == ST_PENDING && kload_valid_i && !kload_start_i)) begin
            err_q <= 1'b1;
        end
    end

    assign kload_err_o = err_q;
`endif

endmodule

// File: tb/tb_conv_window_mac.sv
`timescale 1ns/1ps
// tb_conv_window_mac: table-driven kernel/window vectors, hand-written load corner cases
// and a randomized stream, all checked every cycle against a window-level reference model.
module tb_conv_window_mac;

    localparam int DIV_LATENCY = 5;
    localparam int L = 3 + DIV_LATENCY;

    logic        clock = 1'b0;
    logic        aclr  = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [89:0] in_win = '0;
    logic        kload_start = 1'b0;
    logic        kload_valid = 1'b0;
    logic [7:0]  kload_data = '0;
    logic [22:0] numer;
    logic [14:0] denom;
    logic        mac_valid;
    logic        out_valid;
    logic        out_sof;
    logic        kernel_busy;
`ifdef CONV_LOAD_ERR_EN
    logic        kload_err;
`endif

    always #5 clock = ~clock;

    conv_window_mac #(.DIV_LATENCY(DIV_LATENCY)) dut (
        .clock         (clock),
        .aclr          (aclr),
        .in_valid_i    (in_valid),
        .in_sof_i      (in_sof),
        .in_win_i      (in_win),
        .kload_start_i (kload_start),
        .kload_valid_i (kload_valid),
        .kload_data_i  (kload_data),
        .numer_o       (numer),
        .denom_o       (denom),
        .mac_valid_o   (mac_valid),
        .out_valid_o   (out_valid),
        .out_sof_o     (out_sof),
`ifdef CONV_LOAD_ERR_EN
        .kload_err_o   (kload_err),
`endif
        .kernel_busy_o (kernel_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit vld; bit sof; int numer; int denom; } rec_t;
    rec_t            pipe[$];
    int              hold_numer;
    int              hold_denom;
    logic [8:0][7:0] act_w;
    logic [8:0][7:0] shd_w;
    bit              ready;
    bit              loading;
    int              ld_cnt;

    function automatic int mdl_numer(input logic [89:0] win);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(win[10*i +: 10]) * int'(act_w[i]);
        return s;
    endfunction

    function automatic int mdl_denom();
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(act_w[i]);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic logic [8:0][9:0] fill_pix(input logic [9:0] v);
        logic [8:0][9:0] p;
        for (int i = 0; i < 9; i++) p[i] = v;
        return p;
    endfunction

    function automatic logic [8:0][7:0] fill_w(input logic [7:0] v);
        logic [8:0][7:0] w;
        for (int i = 0; i < 9; i++) w[i] = v;
        return w;
    endfunction

    task automatic model_reset();
        rec_t r;
        r.vld = 0; r.sof = 0; r.numer = 0; r.denom = 1;
        pipe.delete();
        repeat (L) pipe.push_back(r);
        hold_numer = 0;
        hold_denom = 1;
        act_w   = '0;
        act_w[4] = 8'd1;
        shd_w   = '0;
        ready   = 0;
        loading = 0;
        ld_cnt  = 0;
    endtask

    task automatic idle();
        in_valid = 0; in_sof = 0; kload_start = 0; kload_valid = 0;
    endtask

    // One clock: model the window/kernel events presented now, then compare outputs.
    task automatic tick();
        rec_t r;
        r.vld = in_valid;
        r.sof = in_valid && in_sof;
        if (in_valid && in_sof && ready) begin
            act_w = shd_w;
            ready = 0;
        end
        r.numer = mdl_numer(in_win);
        r.denom = mdl_denom();
        if (kload_start) begin
            loading = 1; ld_cnt = 0; ready = 0;
        end
        if (loading && kload_valid) begin
            shd_w[ld_cnt] = kload_data;
            ld_cnt++;
            if (ld_cnt == 9) begin
                loading = 0; ready = 1;
            end
        end
        pipe.push_front(r);
        void'(pipe.pop_back());
        @(posedge clock);
        @(negedge clock);
        if (pipe[2].vld) begin
            hold_numer = pipe[2].numer;
            hold_denom = pipe[2].denom;
        end
        check("mac_valid", mac_valid, pipe[2].vld);
        check("numer", numer, hold_numer);
        check("denom", denom, hold_denom);
        check("denom_nonzero", denom != 15'd0, 1);
        check("out_valid", out_valid, pipe[L-1].vld);
        check("out_sof", out_sof, pipe[L-1].sof);
    endtask

    task automatic pulse_reset();
        idle();
        aclr = 1;
        #2;
        check("rst_numer", numer, 0);
        check("rst_denom", denom, 1);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_busy", kernel_busy, 0);
`ifdef CONV_LOAD_ERR_EN
        check("rst_kload_err", kload_err, 0);
`endif
        @(posedge clock);
        @(negedge clock);
        aclr = 0;
        model_reset();
    endtask

    task automatic load_kernel(input logic [8:0][7:0] w, input bit start_word);
        int first;
        idle();
        kload_start = 1;
        if (start_word) begin
            kload_valid = 1;
            kload_data  = w[0];
        end
        tick();
        kload_start = 0;
        first = start_word ? 1 : 0;
        for (int i = first; i < 9; i++) begin
            kload_valid = 1;
            kload_data  = w[i];
            tick();
        end
        kload_valid = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit              do_load;
        bit              start_word;
        logic [8:0][7:0] wt;
        logic [8:0][9:0] pix;
        int              exp_numer;
        int              exp_denom;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [8:0][9:0] p;
        logic [8:0][7:0] wc;

        vecs[0].do_load = 0; vecs[0].start_word = 0; vecs[0].wt = '0;
        vecs[0].pix = fill_pix(10'd100); vecs[0].pix[4] = 10'd517;
        vecs[0].exp_numer = 517; vecs[0].exp_denom = 1;

        vecs[1].do_load = 1; vecs[1].start_word = 0; vecs[1].wt = fill_w(8'd1);
        vecs[1].pix = fill_pix(10'd100); vecs[1].exp_numer = 900; vecs[1].exp_denom = 9;

        vecs[2].do_load = 1; vecs[2].start_word = 1; vecs[2].wt = fill_w(8'd255);
        vecs[2].pix = fill_pix(10'd1023); vecs[2].exp_numer = 2347785; vecs[2].exp_denom = 2295;

        vecs[3].do_load = 1; vecs[3].start_word = 0; vecs[3].wt = '0;
        vecs[3].pix = fill_pix(10'd500); vecs[3].exp_numer = 0; vecs[3].exp_denom = 1;

        vecs[4].do_load = 1; vecs[4].start_word = 1;
        vecs[4].wt = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
        vecs[4].pix = fill_pix(10'd64); vecs[4].exp_numer = 1024; vecs[4].exp_denom = 16;

        vecs[5].do_load = 1; vecs[5].start_word = 0;
        for (int i = 0; i < 9; i++) begin
            vecs[5].wt[i]  = 8'(i);
            vecs[5].pix[i] = 10'(10 * i);
        end
        vecs[5].exp_numer = 2040; vecs[5].exp_denom = 36;

        model_reset();
        @(negedge clock);
        pulse_reset();

        // Table: optional load, sof window, check at +3 and out_valid/out_sof at +8.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_load) begin
                load_kernel(vecs[v].wt, vecs[v].start_word);
                check("busy_pending", kernel_busy, 1);
            end
            idle();
            tick();
            in_valid = 1; in_sof = 1; in_win = vecs[v].pix;
            tick();
            idle();
            check("busy_after_commit", kernel_busy, 0);
            tick();
            tick();
            check("vec_numer", numer, vecs[v].exp_numer);
            check("vec_denom", denom, vecs[v].exp_denom);
            check("vec_mac_valid", mac_valid, 1);
            repeat (4) tick();
            check("vec_out_valid_early", out_valid, 0);
            tick();
            check("vec_out_valid", out_valid, 1);
            check("vec_out_sof", out_sof, 1);
        end

        // Commit and restart in the same cycle: the completed kernel (all 2) is used first.
        load_kernel(fill_w(8'd2), 0);
        in_valid = 1; in_sof = 1; in_win = fill_pix(10'd10);
        kload_start = 1; kload_valid = 1; kload_data = 8'd3;
        tick();
        idle();
        kload_valid = 1; kload_data = 8'd3;
        tick();
        tick();
        check("same_cycle_numer", numer, 180);
        check("same_cycle_denom", denom, 18);
        check("same_cycle_busy", kernel_busy, 1);
        repeat (6) tick();
        idle();
        tick();
        in_valid = 1; in_sof = 1; in_win = fill_pix(10'd10);
        tick();
        idle();
        tick();
        tick();
        check("restart_numer", numer, 270);
        check("restart_denom", denom, 27);

        // Kernel load finishing mid-frame under back-to-back windows.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 9; k++) p[k] = 10'($urandom_range(0, 1023));
            in_valid = 1;
            in_sof = (i == 0 || i == 30);
            in_win = p;
            kload_start = (i == 5);
            kload_valid = (i >= 6 && i <= 22 && (i % 2 == 0));
            kload_data  = 8'($urandom_range(0, 255));
            tick();
            if (i == 29) check("stream_busy_pending", kernel_busy, 1);
            if (i == 30) check("stream_busy_done", kernel_busy, 0);
        end
        idle();
        repeat (L) tick();

        // sof during a load: old kernel kept; then reset mid-stream.
        idle();
        kload_start = 1;
        tick();
        kload_start = 0;
        for (int i = 0; i < 4; i++) begin
            kload_valid = 1; kload_data = 8'd7;
            tick();
        end
        kload_valid = 0;
        in_valid = 1; in_sof = 1; in_win = fill_pix(10'd200);
        tick();
        idle();
        check("load_sof_busy", kernel_busy, 1);
`ifdef CONV_LOAD_ERR_EN
        check("load_sof_err", kload_err, 1);
`endif
        tick();
        tick();
        wc = '0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 9; k++) p[k] = 10'($urandom_range(0, 1023));
            in_valid = 1; in_sof = (i == 0); in_win = p;
            tick();
        end
        pulse_reset();
        p = fill_pix(10'd300); p[4] = 10'd777;
        in_valid = 1; in_win = p;
        tick();
        idle();
        tick();
        tick();
        check("post_rst_numer", numer, 777);
        check("post_rst_denom", denom, 1);

        // Randomized stream with random loads, restarts and stray words.
        for (int r = 0; r < 1500; r++) begin
            for (int k = 0; k < 9; k++) p[k] = 10'($urandom_range(0, 1023));
            in_valid    = ($urandom_range(0, 3) != 0);
            in_sof      = ($urandom_range(0, 19) == 0);
            in_win      = p;
            kload_start = ($urandom_range(0, 39) == 0);
            kload_valid = ($urandom_range(0, 1) == 1);
            kload_data  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            tick();
            if (r == 700) pulse_reset();
        end
        idle();
        repeat (L) tick();
        if (wc != '0) check("unused_guard", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Convolution multiply-accumulate stage for the image filter datapath. It takes one 3x3 window of 10-bit pixels per cycle from the line-buffer/window generator and produces the weighted sum (`numer`) and the kernel weight sum (`denom`). These feed the 5-cycle pipelined normalising divider directly downstream. The block also owns the 9-tap kernel, loaded serially and committed atomically at frame start. It produces a valid/sof pair aligned to the divider's quotient output.

## Interface
- `DIV_LATENCY`, 5, pipeline depth of the downstream divider; sets the `out_valid`/`out_sof` delay.
- `clock` in 1: rising-edge clock.
- `aclr` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: window valid this cycle.
- `in_sof` in 1: first window of a frame; qualified by `in_valid`.
- `in_win` in 90: pixel i at [10i+9:10i]; i=0 is top-left, row-major, i=8 is bottom-right; unsigned.
- `kload_start` in 1: pulse; restarts kernel load at tap 0.
- `kload_valid` in 1: `kload_data` valid.
- `kload_data` in 8: unsigned weight, taps in order 0..8.
- `numer` out 23: sum of pixel_i*w_i; connects to divider `numer`.
- `denom` out 15: sum of w_i, never 0; connects to divider `denom`.
- `mac_valid` out 1: `numer`/`denom` hold a valid window.
- `out_valid` out 1: divider `quotient` valid.
- `out_sof` out 1: quotient is first pixel of frame.
- `kernel_busy` out 1: high when the load FSM is not IDLE.
- `kload_err` out 1: sticky load error; only present with the macro.

## Operation
- Active kernel register bank w[0..8] and shadow bank s[0..8]. Reset value of the active bank is identity: w[4]=1, all others 0. Active denom register resets to 1.
- The denom register is computed at commit as the sum of s. If that sum is 0 (all-zero kernel), the committed denom is 1. Reason: the divider freezes on denom=0, so denom must never be 0.
- Load FSM:
  - IDLE: `kload_start` -> LOAD, idx=0.
  - LOAD: each `kload_valid` writes s[idx] and increments idx. The write at idx=8 -> PENDING.
  - PENDING: `in_valid & in_sof` -> copy s to w, load denom, -> IDLE.
- `kload_start` in any state -> LOAD, idx=0. If `kload_valid` is asserted in the same cycle, that word is written to s[0] and idx becomes 1.
- Same-cycle `in_sof`/`in_valid` commit and `kload_start` while PENDING: the commit uses the completed shadow first, then the FSM enters LOAD.
- `in_sof` in LOAD: no commit. The old kernel stays in use for the whole frame.
- `kload_valid` in IDLE or PENDING: ignored.
- Pipeline, advancing every cycle with no stalls:
  - S1: 9 products of 10x8 -> 18 bits, using active w.
  - S2: three row sums, 20 bits.
  - S3: total sum, 22 bits, zero-extended to 23.
- The active denom sampled at S1 travels with the window. A commit therefore applies exactly from the sof window onward, and earlier in-flight windows keep the old denom.
- Width bounds: max `numer` = 9*1023*255 = 2347785; max `denom` = 2295. No overflow is possible.
- Between valid windows, `numer`/`denom` hold their last values; `denom` stays nonzero.
- Reset mid-operation:
  - All pipeline and valid/sof delay registers clear, with `numer`=0 and `denom`=1.
  - Active kernel returns to identity.
  - FSM goes to IDLE and the shadow bank clears.

## Timing
- `numer`, `denom` and `mac_valid` appear 3 clocks after the `in_valid` edge.
- `out_valid`/`out_sof` equal `mac_valid` and the pipelined sof delayed DIV_LATENCY clocks, 8 clocks total at default.
- Throughput is one window per clock.
- Commit is visible to the sof window itself. `kernel_busy` drops the cycle after commit.
- Reset values: `numer`=0, `denom`=1, `mac_valid`=0, `out_valid`=0, `out_sof`=0, `kernel_busy`=0, `kload_err`=0.

## Configuration
- `CONV_LOAD_ERR_EN` defined: `kload_err` port exists. It is set and held until `aclr` in two cases:
  - an `in_sof` window arrives while in LOAD;
  - `kload_valid` arrives in PENDING.
- `CONV_LOAD_ERR_EN` undefined: the port and its logic are absent. Load behaviour is otherwise identical.

## Test plan
- Reset, then a window with every pixel 100 except centre 517 -> `numer`=517 and `denom`=1 at +3 clocks; `out_valid` at +8.
- Load nine weights of 1, then an sof window of all 100 -> `numer`=900, `denom`=9. The quotient stage would give 100.
- Load nine weights of 255, then an sof window of all 1023 -> `numer`=2347785, `denom`=2295.
- Load all-zero weights, then sof -> `numer`=0, `denom`=1; `denom` is never 0 at any cycle.
- Finish a load mid-frame while streaming back-to-back windows:
  - the old kernel is used until the next sof window; the new kernel applies from that sof on;
  - `out_valid` pattern equals `in_valid` shifted by 8.
- Send sof while in LOAD -> the old kernel is retained; with the macro, `kload_err`=1. Then pulse `aclr` mid-stream -> all outputs return to reset values and the identity kernel is active.
